// File: rtl/cp0_pkg.sv
// cp0_pkg -- shared constants for the coprocessor-0 exception/interrupt unit.
//   Register numbers addressed by mfc0/mtc0, exception codes written into
//   Cause.ExcCode, and the bit-field positions of SR and Cause.
package cp0_pkg;

  // Register numbers
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // Exception codes
  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  // SR fields
  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int SR_IM_LO = 10;
  localparam int SR_IM_HI = 15;

  // Cause fields
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

endpackage

// File: rtl/cp0.sv
// cp0 -- coprocessor-0 exception/interrupt unit, sits at the M stage.
//   Holds SR, Cause and EPC; raises req to flush the pipeline and redirect
//   fetch to the handler; serves mfc0 (A1/Dout), mtc0 (A2/Din/WE) and eret
//   (EXLClr/EPCOut).
// Ports:
//   clk, reset     single clock, synchronous active-high reset
//   A1             mfc0 read register number
//   A2, Din, WE    mtc0 write register number, data, enable
//   VPC, BDIn      victim PC and branch-delay-slot flag of the M instruction
//   ExcCodeIn      synchronous exception code (0 = none)
//   HWInt          interrupt lines: [0] tc0, [1] tc1, [2] external
//   EXLClr         eret in M
//   Dout           read data for A1 (combinational, no forwarding)
//   EPCOut         current EPC, the eret target
//   Req            take exception/interrupt this cycle
// Configuration macro: CP0_PRID_EN -- when defined, register 15 reads
//   PRID_VALUE; otherwise it reads 0 like any unimplemented number.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h0000_4D49
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] Din,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] Dout,
  output logic [31:0] EPCOut,
  output logic        Req
);

  // Architectural state
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // EXL masks both sources, so a handler can never be re-entered.
  assign int_req = (|(HWInt & im)) & ie & ~exl;
  assign exc_req = (ExcCodeIn != EXC_INT) & ~exl;
  assign Req     = int_req | exc_req;

  always_comb begin
    sr_word                      = '0;
    sr_word[SR_IM_HI:SR_IM_LO]   = im;
    sr_word[SR_EXL]              = exl;
    sr_word[SR_IE]               = ie;
  end

  always_comb begin
    cause_word                            = '0;
    cause_word[CAUSE_BD]                  = bd;
    cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
    cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code;
  end

`ifndef CP0_PRID_EN
  // PRID_VALUE is only consumed when the PRId register is compiled in.
  logic unused_prid;
  assign unused_prid = ^PRID_VALUE;
`endif

  always_comb begin
    Dout = '0;
    case (A1)
      REG_SR:    Dout = sr_word;
      REG_CAUSE: Dout = cause_word;
      REG_EPC:   Dout = epc;
`ifdef CP0_PRID_EN
      REG_PRID:  Dout = PRID_VALUE;
`endif
      default:   Dout = '0;
    endcase
  end

  assign EPCOut = epc;

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        // The M instruction is flushed, so any concurrent mtc0 or eret is dropped.
        exl      <= 1'b1;
        exc_code <= int_req ? EXC_INT : ExcCodeIn;
        bd       <= BDIn;
        epc      <= BDIn ? (VPC - 32'd4) : VPC;
      end else begin
        if (EXLClr) begin
          exl <= 1'b0;
        end
        if (WE) begin
          case (A2)
            REG_SR: begin
              im  <= Din[SR_IM_HI:SR_IM_LO];
              exl <= Din[SR_EXL];
              ie  <= Din[SR_IE];
            end
            REG_EPC: epc <= Din;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0.sv
module tb_cp0;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, ExcCodeIn;
  logic [31:0] Din, VPC;
  logic        WE, BDIn, EXLClr;
  logic [5:0]  HWInt;
  logic [31:0] Dout, EPCOut;
  logic        Req;

  int checks = 0;
  int failures = 0;

`ifdef CP0_PRID_EN
  localparam logic [31:0] PRID_EXP = 32'h0000_4D49;
`else
  localparam logic [31:0] PRID_EXP = 32'h0;
`endif

  cp0 dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .Din(Din), .WE(WE),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .Dout(Dout), .EPCOut(EPCOut), .Req(Req)
  );

  always #5 clk = ~clk;

  // Reference model: the three registers kept as whole 32-bit words.
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic model_irq();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic model_req();
    return model_irq() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_EXP;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic        irq, req;
    logic [31:0] sr_n, cause_n, epc_n;
    irq = model_irq();
    req = model_req();
    sr_n = m_sr; cause_n = m_cause; epc_n = m_epc;
    cause_n[15:10] = HWInt;
    if (req) begin
      sr_n = sr_n | 32'h2;
      cause_n[31] = BDIn;
      cause_n[6:2] = irq ? 5'd0 : ExcCodeIn;
      epc_n = VPC - (BDIn ? 32'd4 : 32'd0);
    end else begin
      if (EXLClr) sr_n = sr_n & ~32'h2;
      if (WE && A2 == 5'd12) sr_n = Din & 32'h0000_FC03;
      if (WE && A2 == 5'd14) epc_n = Din;
    end
    if (reset) begin
      sr_n = 0; cause_n = 0; epc_n = 0;
    end
    m_sr = sr_n; m_cause = cause_n; m_epc = epc_n;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; WE = 0; A2 = 0; Din = 0; BDIn = 0; ExcCodeIn = 0; EXLClr = 0;
  endtask

  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    idle(); A1 = 5'd12; VPC = 32'h3000; HWInt = 0;

    // Reset state
    reset = 1; step(); step(); reset = 0; #1;
    check("rst_req", {31'b0, Req}, 32'd0);
    check("rst_sr", Dout, 32'h0);
    check("rst_epc", EPCOut, 32'h0);

    // Enable all interrupt masks with IE, then raise tc0
    WE = 1; A2 = 5'd12; Din = 32'h0000_FC01; step(); WE = 0;
    HWInt = 6'b000001; VPC = 32'h3000; #1;
    check("int_req", {31'b0, Req}, 32'd1);
    step(); HWInt = 0;
    A1 = 5'd12; #1; check("int_sr", Dout, 32'h0000_FC03);
    A1 = 5'd13; #1; check("int_cause", Dout, 32'h0000_0400);
    check("int_epc", EPCOut, 32'h3000);
    check("int_noreq_exl", {31'b0, Req}, 32'd0);

    // Overflow in a delay slot
    EXLClr = 1; step(); EXLClr = 0;
    ExcCodeIn = 5'd12; VPC = 32'h3010; BDIn = 1; #1;
    check("ov_req", {31'b0, Req}, 32'd1);
    step(); idle();
    A1 = 5'd13; #1;
    check("ov_epc", EPCOut, 32'h300C);
    check("ov_cause", Dout, 32'h8000_0030);

    // mtc0 EPC in a Req cycle is discarded
    EXLClr = 1; step(); EXLClr = 0;
    WE = 1; A2 = 5'd14; Din = 32'h1234; ExcCodeIn = 5'd4; VPC = 32'h3040; #1;
    check("wr_req", {31'b0, Req}, 32'd1);
    step(); idle(); #1;
    check("wr_drop_epc", EPCOut, 32'h3040);

    // EXL blocks requests until the edge after eret
    ExcCodeIn = 5'd10; HWInt = 6'b000001; #1;
    check("exl_block", {31'b0, Req}, 32'd0);
    step(); ExcCodeIn = 0; EXLClr = 1; #1;
    check("exl_eret_cycle", {31'b0, Req}, 32'd0);
    step(); EXLClr = 0; VPC = 32'h3020; #1;
    check("eret_rearm", {31'b0, Req}, 32'd1);
    step(); #1;
    check("handler_epc", EPCOut, 32'h3020);

    // Reset mid-handler
    reset = 1; EXLClr = 1; WE = 1; A2 = 5'd14; Din = 32'hDEAD; step(); idle(); HWInt = 0; #1;
    check("mid_rst_req", {31'b0, Req}, 32'd0);
    check("mid_rst_epc", EPCOut, 32'h0);
    A1 = 5'd12; #1; check("mid_rst_sr", Dout, 32'h0);
    A1 = 5'd13; #1; check("mid_rst_cause", Dout, 32'h0);

    // PRId and unimplemented numbers
    A1 = 5'd15; #1; check("prid", Dout, PRID_EXP);
    A1 = 5'd3;  #1; check("unimpl", Dout, 32'h0);

    // mtc0 EPC with eret: write lands, old EPC visible this cycle
    WE = 1; A2 = 5'd14; Din = 32'h0000_5000; step();
    Din = 32'h0000_6000; EXLClr = 1; #1;
    check("eret_old_epc", EPCOut, 32'h5000);
    step(); idle(); #1;
    check("eret_new_epc", EPCOut, 32'h6000);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 60) == 0);
      WE        = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0, 1:    A2 = 5'd12;
        2:       A2 = 5'd14;
        3:       A2 = 5'd13 + 5'($urandom_range(0, 2));
        default: A2 = 5'($urandom);
      endcase
      Din       = (A2 == 5'd12) ? ($urandom & 32'h0000_FC03) | 32'($urandom_range(0, 1)) : $urandom;
      VPC       = $urandom & 32'hFFFF_FFFC;
      BDIn      = 1'($urandom);
      ExcCodeIn = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
      HWInt     = {3'b000, 3'($urandom)};
      EXLClr    = ($urandom_range(0, 3) == 0);
      A1        = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd12 + 5'($urandom_range(0, 3));
      #1;
      check("rnd_req", {31'b0, Req}, {31'b0, model_req()});
      check("rnd_dout", Dout, model_read(A1));
      check("rnd_epc", EPCOut, m_epc);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 exception/interrupt unit for the five-stage pipelined processor, instantiated inside `Processor` at the M stage. It consumes the 6-bit `HWInt` vector that the top level assembles from `tc0_irq`, `tc1_irq` and the external `interrupt` line. It also takes the M-stage PC and the synchronous exception code. It holds SR, Cause and EPC, raises `Req` to flush the pipeline and redirect fetch to the handler, and serves `mfc0`, `mtc0` and `eret`.

## Interface
Parameters:
- `PRID_VALUE`, default 32'h0000_4D49: constant returned for register 15 when PRId is compiled in.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `A1`  in  5  `mfc0` read register number.
- `A2`  in  5  `mtc0` write register number.
- `Din`  in  32  `mtc0` write data.
- `WE`  in  1  `mtc0` write enable (M stage).
- `VPC`  in  32  victim PC, the M-stage instruction address.
- `BDIn`  in  1  M-stage instruction is in a branch delay slot.
- `ExcCodeIn`  in  5  synchronous exception code from M. 0 = none.
- `HWInt`  in  6  hardware interrupt lines: [0] tc0, [1] tc1, [2] external, [5:3] zero.
- `EXLClr`  in  1  `eret` in M stage.
- `Dout`  out  32  read data for register `A1`.
- `EPCOut`  out  32  current EPC, used as the `eret` target.
- `Req`  out  1  take exception/interrupt this cycle.

## Operation
Registers:
- SR (12): bits IM[15:10], EXL[1] and IE[0] are writable; all other bits read 0.
- Cause (13): BD[31], IP[15:10] and ExcCode[6:2]. Read-only to `mtc0`.
- EPC (14): fully writable.
- Reads of any other number return 0.

Request logic:
- `IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL`.
- `ExcReq = (ExcCodeIn != 0) & ~SR.EXL`.
- `Req = IntReq | ExcReq`.
- Interrupt has priority over exception.

On `Req` at the clock edge:
- EXL <= 1.
- ExcCode <= `IntReq ? 0 : ExcCodeIn`.
- BD <= `BDIn`.
- EPC <= `BDIn ? VPC-4 : VPC`, taken mod 2^32.

Other updates:
- Cause.IP <= `HWInt` on every edge, independent of `Req`.
- `EXLClr` with no `Req` in the same cycle: EXL <= 0.
- `mtc0` executes only when `WE & ~Req`. A write in a `Req` cycle is discarded, because the instruction is being flushed.
- `Req` and `EXLClr` in the same cycle: `Req` wins and EXL ends at 1.
- `mtc0` to EPC in the same cycle as `EXLClr`: the EPC write lands. `EPCOut` shows the old EPC this cycle.

## Timing
- Reset: SR, Cause and EPC are all 0, so `Req` = 0, `Dout` = 0 and `EPCOut` = 0 in the cycle after `reset`.
- `reset` overrides every concurrent write, request and `EXLClr`.
- `Req`, `Dout` and `EPCOut` are combinational from the current register state and the inputs. There is no read forwarding: `mfc0` sees pre-edge values.
- All state updates take effect at the posedge, with 1-cycle latency.
- Once EXL = 1, `Req` stays 0 until the edge after `EXLClr`. This gives no nesting.
- A level `HWInt` held through `eret` re-raises `Req` in the cycle after EXL clears.

## Configuration
- Macro `CP0_PRID_EN`.
- Defined: register 15 reads `PRID_VALUE`. Writes to it are ignored.
- Undefined: register 15 reads 0, like any unimplemented number.

## Structure
- Package `cp0_pkg` holds:
  - Register numbers: SR = 12, CAUSE = 13, EPC = 14, PRID = 15.
  - ExcCode constants: INT = 0, ADEL = 4, ADES = 5, SYSCALL = 8, RI = 10, OV = 12.
  - SR/Cause bit-field positions.
- The block is flat with no sub-module. The request logic is a few gates.

## Test plan
- Reset, then SR = 0x0000_FC01 via `mtc0`; HWInt = 6'b000001 -> `Req` = 1 the same cycle. Next cycle EXL = 1, Cause = 0x0000_0400, EPC = `VPC`.
- EXL = 0, `ExcCodeIn` = 12 (Ov), `VPC` = 0x3010, `BDIn` = 1 -> `Req` = 1. Next cycle EPC = 0x300C, Cause = 0x8000_0030.
- Simultaneous `WE` (A2 = 14, Din = 0x1234) and `Req` -> EPC = `VPC`, not 0x1234.
- EXL = 1 with `ExcCodeIn` = 10 and HWInt active -> `Req` = 0. After `EXLClr` with HWInt still high, `Req` = 1 one cycle later.
- `reset` asserted mid-handler (EXL = 1, EPC = 0x3020) -> all registers 0 next cycle, `Req` = 0.
- Read A1 = 15: `Dout` = 0x0000_4D49 with `CP0_PRID_EN` defined, 0 without it.
